// File: rtl/mmio_data_memory.sv
// CPU data memory: general RAM, screen framebuffer and keyboard register in one address space,
// plus a post-reset screen-clear engine and a valid/ready framebuffer scan-out port.
module mmio_data_memory #(
    parameter int               DATA_W       = 16,
    parameter int               ADDR_W       = 15,
    parameter int               RAM_WORDS    = 16384,
    parameter int               SCREEN_BASE  = 16384,
    parameter int               SCREEN_WORDS = 8192,
    parameter int               KBD_ADDR     = 24576,
    parameter logic [DATA_W-1:0] SCREEN_FILL = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [ADDR_W-1:0]               adr,
    input  logic [DATA_W-1:0]               d_in,
    output logic [DATA_W-1:0]               d_out,
    input  logic [DATA_W-1:0]               kb_in,
    output logic                            busy,
    input  logic                            scan_en,
    input  logic                            scan_ready,
    output logic                            scan_valid,
    output logic [DATA_W-1:0]               scan_data,
    output logic [$clog2(SCREEN_WORDS)-1:0] scan_idx,
    output logic                            scan_sof
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    typedef enum logic {CLEAR, RUN} state_t;

    logic [DATA_W-1:0] ram    [RAM_WORDS];
    logic [DATA_W-1:0] screen [SCREEN_WORDS];
    logic [DATA_W-1:0] kbd_q;
    state_t            state_q, state_d;
    logic [SCR_AW-1:0] clr_ptr;
    logic [SCR_AW-1:0] scan_ptr;
    logic [SCR_AW-1:0] scr_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              in_ram, in_scr, is_kbd, scan_load;

    assign in_ram  = 32'(adr) < RAM_WORDS;
    assign in_scr  = (32'(adr) >= SCREEN_BASE) && (32'(adr) < SCREEN_BASE + SCREEN_WORDS);
    assign is_kbd  = 32'(adr) == KBD_ADDR;
    assign scr_idx = SCR_AW'(adr - ADDR_W'(SCREEN_BASE));
    assign ram_idx = RAM_AW'(adr);

    always_comb begin
        d_out = '0;
        if (in_ram)
            d_out = ram[ram_idx];
        else if (in_scr)
            d_out = screen[scr_idx];
        else if (is_kbd)
            d_out = kbd_q;
    end

    always_ff @(posedge clk) begin
        if (load && in_ram)
            ram[ram_idx] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (rst)
            kbd_q <= '0;
        else
            kbd_q <= kb_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            CLEAR: begin
                busy = 1'b1;
                if (clr_ptr == SCR_AW'(SCREEN_WORDS - 1))
                    state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // The clear engine owns the write port while busy; CPU screen writes are dropped then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)
                screen[clr_ptr] <= SCREEN_FILL;
            else if (load && in_scr)
                screen[scr_idx] <= d_in;
        end
    end

    assign scan_load = (state_q == RUN) && scan_en && (!scan_valid || scan_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_valid <= 1'b0;
            scan_idx   <= '0;
            scan_data  <= '0;
            scan_ptr   <= '0;
        end else if (scan_load) begin
            scan_data  <= screen[scan_ptr];
            scan_idx   <= scan_ptr;
            scan_valid <= 1'b1;
            scan_ptr   <= scan_ptr + 1'b1;
        end else begin
            if (scan_valid && scan_ready)
                scan_valid <= 1'b0;
            if (!scan_valid && !scan_en)
                scan_ptr <= '0;
        end
    end

    assign scan_sof = scan_valid && (scan_idx == '0);
endmodule

// File: tb/tb_mmio_data_memory.sv
// Scoreboard bench for mmio_data_memory: CPU decode, clear engine, keyboard lag and scan-out streaming.
module tb_mmio_data_memory;
    logic        clk = 1'b0;
    logic        rst, load, busy, scan_en, scan_ready, scan_valid, scan_sof;
    logic [14:0] adr;
    logic [15:0] d_in, d_out, kb_in, scan_data;
    logic [12:0] scan_idx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [12:0] idx;
        logic [15:0] data;
    } beat_t;

    logic [15:0] model [8192];
    beat_t       sbq [$];

    mmio_data_memory dut (
        .clk(clk), .rst(rst), .load(load), .adr(adr), .d_in(d_in), .d_out(d_out),
        .kb_in(kb_in), .busy(busy), .scan_en(scan_en), .scan_ready(scan_ready),
        .scan_valid(scan_valid), .scan_data(scan_data), .scan_idx(scan_idx), .scan_sof(scan_sof)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int first, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.idx  = 13'((first + k) % 8192);
            b.data = model[b.idx];
            sbq.push_back(b);
        end
    endtask

    task automatic test_reset;
        rst = 1; load = 0; adr = 15'd24576; d_in = 0; kb_in = 16'h0077; scan_en = 0; scan_ready = 0;
        tick; tick;
        total += 6;
        if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
        if (scan_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", scan_valid); end
        if (scan_idx !== 13'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", scan_idx); end
        if (scan_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want=0000", scan_data); end
        if (scan_sof !== 1'b0) begin bad++; $display("FAIL rst_sof got=%b want=0", scan_sof); end
        if (d_out !== 16'h0) begin bad++; $display("FAIL rst_kbd got=%h want=0000", d_out); end
    endtask

    task automatic test_clear;
        int n;
        rst = 0; kb_in = 0;
        load = 1; adr = 15'd16384; d_in = 16'hABCD;
        tick; n = 1;
        adr = 15'd100; d_in = 16'h1234;
        tick; n = 2;
        load = 0;
        while (busy && n < 9000) begin
            if (n == 10) begin load = 1; adr = 15'd16389; d_in = 16'hABCD; end
            else load = 0;
            tick; n++;
        end
        load = 0;
        total++;
        if (n !== 8192) begin bad++; $display("FAIL clear_cycles got=%0d want=8192", n); end
        for (int i = 0; i < 8192; i++) begin
            adr = 15'(16384 + i); #1;
            total++;
            if (d_out !== 16'h0000) begin bad++; $display("FAIL clear_word %0d got=%h want=0000", i, d_out); end
        end
        adr = 15'd100; #1;
        total++;
        if (d_out !== 16'h1234) begin bad++; $display("FAIL ram_during_clear got=%h want=1234", d_out); end
    endtask

    task automatic test_ram_persist;
        int n;
        load = 1; adr = 15'd5; d_in = 16'h5A5A; tick;
        adr = 15'd16391; d_in = 16'h7777; tick;
        load = 0; adr = 15'd16391; #1;
        total++;
        if (d_out !== 16'h7777) begin bad++; $display("FAIL scr_write got=%h want=7777", d_out); end
        rst = 1; tick; rst = 0;
        n = 0;
        while (busy && n < 9000) begin tick; n++; end
        adr = 15'd5; #1;
        total += 3;
        if (n !== 8192) begin bad++; $display("FAIL reclear_cycles got=%0d want=8192", n); end
        if (d_out !== 16'h5A5A) begin bad++; $display("FAIL ram_keep got=%h want=5a5a", d_out); end
        adr = 15'd16391; #1;
        if (d_out !== 16'h0000) begin bad++; $display("FAIL scr_recleared got=%h want=0000", d_out); end
    endtask

    task automatic test_kbd_decode;
        kb_in = 16'h0000; adr = 15'd24576; tick;
        kb_in = 16'h0041; #1;
        total += 6;
        if (d_out !== 16'h0000) begin bad++; $display("FAIL kbd_lag got=%h want=0000", d_out); end
        tick;
        if (d_out !== 16'h0041) begin bad++; $display("FAIL kbd_read got=%h want=0041", d_out); end
        load = 1; d_in = 16'hFFFF; tick;
        adr = 15'd30000; d_in = 16'hBEEF; tick;
        load = 0; adr = 15'd24576; #1;
        if (d_out !== 16'h0041) begin bad++; $display("FAIL kbd_write_ignored got=%h want=0041", d_out); end
        adr = 15'd30000; #1;
        if (d_out !== 16'h0000) begin bad++; $display("FAIL unmapped_read got=%h want=0000", d_out); end
        load = 1; adr = 15'd16383; d_in = 16'h3FFF; tick;
        adr = 15'd24575; d_in = 16'h1FFF; tick;
        load = 0; model[8191] = 16'h1FFF;
        adr = 15'd16383; #1;
        if (d_out !== 16'h3FFF) begin bad++; $display("FAIL ram_top got=%h want=3fff", d_out); end
        adr = 15'd24575; #1;
        if (d_out !== 16'h1FFF) begin bad++; $display("FAIL scr_top got=%h want=1fff", d_out); end
    endtask

    task automatic test_scan_stream;
        int nb, cyc, sofs;
        beat_t e;
        for (int i = 0; i < 256; i++) begin
            load = 1; adr = 15'(16384 + i); d_in = 16'(i * 7 + 3);
            model[i] = 16'(i * 7 + 3);
            tick;
        end
        load = 0;
        push_frame(0, 8192);
        push_frame(0, 2);
        scan_en = 1; scan_ready = 1; #1;
        total += 4;
        if (scan_valid !== 1'b0) begin bad++; $display("FAIL scan_pre got=%b want=0", scan_valid); end
        tick;
        if (scan_valid !== 1'b1) begin bad++; $display("FAIL scan_first_valid got=%b want=1", scan_valid); end
        if (scan_idx !== 13'd0) begin bad++; $display("FAIL scan_first_idx got=%0d want=0", scan_idx); end
        if (scan_sof !== 1'b1) begin bad++; $display("FAIL scan_first_sof got=%b want=1", scan_sof); end
        nb = 0; cyc = 0; sofs = 0;
        while (nb < 8194 && cyc < 9000) begin
            if (scan_valid && scan_ready) begin
                total += 3;
                if (sbq.size() == 0) begin bad++; $display("FAIL sb_underflow got=empty want=beat"); end
                else begin
                    e = sbq.pop_front();
                    if (scan_idx !== e.idx) begin bad++; $display("FAIL beat_idx got=%0d want=%0d", scan_idx, e.idx); end
                    if (scan_data !== e.data) begin bad++; $display("FAIL beat_data idx=%0d got=%h want=%h", e.idx, scan_data, e.data); end
                    if (scan_sof !== (e.idx == 13'd0)) begin bad++; $display("FAIL beat_sof idx=%0d got=%b", e.idx, scan_sof); end
                end
                if (scan_sof) sofs++;
                nb++;
            end
            tick; cyc++;
        end
        total += 2;
        if (nb !== 8194) begin bad++; $display("FAIL stream_beats got=%0d want=8194", nb); end
        if (sofs !== 2) begin bad++; $display("FAIL stream_sofs got=%0d want=2", sofs); end
    endtask

    task automatic test_scan_en_low;
        scan_ready = 0; scan_en = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            total += 2;
            if (scan_valid !== 1'b1) begin bad++; $display("FAIL en_low_hold_valid got=%b want=1", scan_valid); end
            if (scan_idx !== 13'd2) begin bad++; $display("FAIL en_low_hold_idx got=%0d want=2", scan_idx); end
        end
        scan_ready = 1; tick; tick;
        total++;
        if (scan_valid !== 1'b0) begin bad++; $display("FAIL en_low_drain got=%b want=0", scan_valid); end
        sbq.delete();
    endtask

    task automatic test_stall_rdw;
        int nb, cyc;
        bit stalled, rdw_done;
        logic [15:0] held;
        beat_t e;
        push_frame(0, 8192);
        scan_en = 1; scan_ready = 1;
        nb = 0; cyc = 0; stalled = 0; rdw_done = 0;
        while (nb < 8192 + 41 && cyc < 9500) begin
            if (!stalled && scan_valid && scan_idx == 13'd37) begin
                scan_ready = 0; held = scan_data; stalled = 1;
                for (int k = 0; k < 5; k++) begin
                    tick;
                    total += 3;
                    if (scan_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", scan_valid); end
                    if (scan_idx !== 13'd37) begin bad++; $display("FAIL stall_idx got=%0d want=37", scan_idx); end
                    if (scan_data !== held) begin bad++; $display("FAIL stall_data got=%h want=%h", scan_data, held); end
                end
                scan_ready = 1;
            end
            if (scan_valid && scan_ready) begin
                total += 2;
                if (sbq.size() == 0) begin bad++; $display("FAIL sb_underflow got=empty want=beat"); end
                else begin
                    e = sbq.pop_front();
                    if (scan_idx !== e.idx) begin bad++; $display("FAIL beat_idx got=%0d want=%0d", scan_idx, e.idx); end
                    if (scan_data !== e.data) begin bad++; $display("FAIL beat_data idx=%0d got=%h want=%h", e.idx, scan_data, e.data); end
                end
                nb++;
            end
            if (!rdw_done && scan_valid && scan_ready && scan_idx == 13'd39) begin
                load = 1; adr = 15'(16384 + 40); d_in = 16'h00FF;
                rdw_done = 1;
            end
            tick; cyc++;
            if (load) begin
                load = 0;
                model[40] = 16'h00FF;
                push_frame(0, 41);
            end
        end
        adr = 15'(16384 + 40); #1;
        total += 3;
        if (nb !== 8192 + 41) begin bad++; $display("FAIL rdw_beats got=%0d want=%0d", nb, 8192 + 41); end
        if (!stalled || !rdw_done) begin bad++; $display("FAIL scenario_reached got=%0b%0b want=11", stalled, rdw_done); end
        if (d_out !== 16'h00FF) begin bad++; $display("FAIL rdw_cpu_read got=%h want=00ff", d_out); end
        scan_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) model[i] = 16'h0000;
        test_reset;
        test_clear;
        test_ram_persist;
        test_kbd_decode;
        test_scan_stream;
        test_scan_en_low;
        test_stall_rdw;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
